// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares a single uart_tx transmitter among N byte requesters. A round-robin
// arbiter picks the next requester whenever the transmitter is idle. Each
// accepted byte is acknowledged with a one-cycle req_ready pulse. A requester
// that holds req_lock keeps the transmitter for back-to-back bytes. A
// watchdog aborts a frame when the transmitter never takes the send request.
//
// Parameters
//   N         number of requesters (2..8)
//   START_TO  clk cycles allowed between tx_send rising and tx_ready falling
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   req_valid_i    [N]   requester i presents a byte
//   req_data_i     [8N]  packed bytes, requester i at [8i+7:8i]
//   req_lock_i     [N]   requester i keeps the grant after its current byte
//   req_ready_o    [N]   one-cycle accept pulse, one-hot or zero
//   tx_ready_i           uart_tx idle indication
//   tx_send_o            send request to uart_tx
//   tx_data_o      [8]   byte for uart_tx, held for the whole frame
//   grant_id_o     [3]   current or last granted requester
//   busy_o               high whenever a frame is being scheduled or sent
//   err_timeout_o        one-cycle pulse when the watchdog aborts a frame
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int N        = 4,
  parameter int START_TO = 4096
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_valid_i,
  input  logic [8*N-1:0] req_data_i,
  input  logic [N-1:0]   req_lock_i,
  output logic [N-1:0]   req_ready_o,
  input  logic           tx_ready_i,
  output logic           tx_send_o,
  output logic [7:0]     tx_data_o,
  output logic [2:0]     grant_id_o,
  output logic           busy_o,
  output logic           err_timeout_o
);

  localparam int PTR_W = $clog2(N);
  localparam int WD_W  = $clog2(START_TO);

  // IDLE: arbitrate; START: send held, waiting for uart_tx to start;
  // RUN: frame on the line, waiting for uart_tx to become idle again.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic [7:0]       data_q, data_d;
  logic [N-1:0]     ready_q, ready_d;
  logic             send_q, send_d;
  logic             err_q, err_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  // Round-robin arbiter: first valid requester at or above rr_q, wrapping.
  logic [PTR_W-1:0] winner;
  logic             any_valid;

  always_comb begin : arb
    int idx;
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    idx       = 0;
    winner    = rr_q;
    any_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!any_valid && req_valid_i[PTR_W'(idx)]) begin
        any_valid = 1'b1;
        winner    = PTR_W'(idx);
      end
    end
  end

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(N - 1)) ? '0 : v + PTR_W'(1);
  endfunction

  // State register. rst_i wins over everything, including a frame in
  // flight; uart_tx completes that frame on its own.
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst_i) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      data_q  <= '0;
      ready_q <= '0;
      send_q  <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      send_q  <= send_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state logic.
  logic             do_accept;
  logic [PTR_W-1:0] acc_id;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    ready_d   = '0;
    send_d    = send_q;
    err_d     = 1'b0;
    wd_d      = wd_q;
    do_accept = 1'b0;
    acc_id    = winner;

    unique case (state_q)
      S_IDLE: begin
        // Never grant while uart_tx is still busy with an earlier frame.
        if (tx_ready_i && any_valid) begin
          do_accept = 1'b1;
          acc_id    = winner;
        end
      end

      S_START: begin
        if (!tx_ready_i) begin
          send_d  = 1'b0;
          state_d = S_RUN;
        end else if (wd_q == WD_W'(START_TO - 1)) begin
          // Transmitter never started: drop the byte, move fairness on.
          send_d  = 1'b0;
          err_d   = 1'b1;
          rr_d    = next_ptr(grant_q);
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      S_RUN: begin
        if (tx_ready_i) begin
          if (req_lock_i[grant_q] && req_valid_i[grant_q]) begin
            // Locked requester with another byte: keep the transmitter,
            // round-robin pointer untouched.
            do_accept = 1'b1;
            acc_id    = grant_q;
          end else begin
            rr_d    = next_ptr(grant_q);
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Byte is captured only on the accept edge; later req_data changes
    // cannot disturb the frame.
    if (do_accept) begin
      grant_d         = acc_id;
      data_d          = req_data_i[{acc_id, 3'b000} +: 8];
      ready_d[acc_id] = 1'b1;
      send_d          = 1'b1;
      wd_d            = '0;
      state_d         = S_START;
    end
  end

  // Outputs.
  always_comb begin
    req_ready_o   = ready_q;
    tx_send_o     = send_q;
    tx_data_o     = data_q;
    grant_id_o    = 3'(grant_q);
    busy_o        = (state_q != S_IDLE);
    err_timeout_o = err_q;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Drives uart_tx_scheduler (N=4, START_TO=16) through directed scenarios with
// a simple uart_tx model. A transaction-level reference model of the
// scheduler is compared against every output after every clock edge, and
// each scenario also checks hand-computed grant/data sequences.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int N         = 4;
  localparam int START_TO  = 16;
  localparam int FRAME_CYC = 100;
  localparam int BOUND     = 400;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_lock_i;
  logic [N-1:0]   req_ready_o;
  logic           tx_ready_i;
  logic           tx_send_o;
  logic [7:0]     tx_data_o;
  logic [2:0]     grant_id_o;
  logic           busy_o;
  logic           err_timeout_o;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.N(N), .START_TO(START_TO)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_data_i    (req_data_i),
    .req_lock_i    (req_lock_i),
    .req_ready_o   (req_ready_o),
    .tx_ready_i    (tx_ready_i),
    .tx_send_o     (tx_send_o),
    .tx_data_o     (tx_data_o),
    .grant_id_o    (grant_id_o),
    .busy_o        (busy_o),
    .err_timeout_o (err_timeout_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur within %0d cycles", name, BOUND);
  endtask

  // -------------------------------------------------------------------------
  // uart_tx model: send seen while idle -> ready drops a few cycles later,
  // stays low for the frame, then returns high. In manual mode the scenario
  // drives tx_ready itself.
  // -------------------------------------------------------------------------
  logic manual = 1'b0;

  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (!manual && tx_send_o === 1'b1 && tx_ready_i) begin
        repeat (4) @(negedge clk);
        tx_ready_i = 1'b0;
        repeat (FRAME_CYC) @(negedge clk);
        tx_ready_i = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Reference model. Phases: 0 = free for arbitration, 1 = send offered to
  // the transmitter, 2 = frame on the line. Inputs are taken as they stand
  // at the clock edge; outputs are compared 1 time unit later.
  // -------------------------------------------------------------------------
  int         m_phase = 0;
  int         m_rr    = 0;
  int         m_g     = 0;
  int         m_edges = 0;
  logic [7:0] m_data  = '0;
  logic       m_send  = 1'b0;
  logic       m_err   = 1'b0;
  logic [N-1:0] m_ready = '0;

  int log_g[$];
  int log_d[$];

  function automatic int pick(input int rr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (((v >> j) & N'(1)) != '0) return j;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      logic           s_rst, s_rdy;
      logic [N-1:0]   s_v, s_lk;
      logic [8*N-1:0] s_d;
      int             acc;
      @(posedge clk);
      s_rst = rst_i;
      s_rdy = tx_ready_i;
      s_v   = req_valid_i;
      s_lk  = req_lock_i;
      s_d   = req_data_i;
      acc   = -1;
      m_ready = '0;
      m_err   = 1'b0;
      if (s_rst) begin
        m_phase = 0; m_rr = 0; m_g = 0; m_data = '0; m_send = 1'b0; m_edges = 0;
      end else if (m_phase == 0) begin
        if (s_rdy && s_v != '0) acc = pick(m_rr, s_v);
      end else if (m_phase == 1) begin
        m_edges++;
        if (!s_rdy) begin
          m_send = 1'b0; m_phase = 2;
        end else if (m_edges == START_TO) begin
          m_send = 1'b0; m_err = 1'b1; m_rr = (m_g + 1) % N; m_phase = 0;
        end
      end else begin
        if (s_rdy) begin
          if (((s_lk >> m_g) & N'(1)) != '0 && ((s_v >> m_g) & N'(1)) != '0) acc = m_g;
          else begin
            m_rr = (m_g + 1) % N; m_phase = 0;
          end
        end
      end
      if (acc >= 0) begin
        m_g     = acc;
        m_data  = 8'(s_d >> (8 * acc));
        m_ready = N'(1) << acc;
        m_send  = 1'b1;
        m_phase = 1;
        m_edges = 0;
      end
      #1;
      check("req_ready",   req_ready_o,   m_ready);
      check("tx_send",     tx_send_o,     m_send);
      check("tx_data",     tx_data_o,     m_data);
      check("grant_id",    grant_id_o,    m_g);
      check("busy",        busy_o,        m_phase != 0);
      check("err_timeout", err_timeout_o, m_err);
      if (req_ready_o != '0) begin
        log_g.push_back(int'(grant_id_o));
        log_d.push_back(int'(tx_data_o));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scenario helpers (all called on a falling edge).
  // -------------------------------------------------------------------------
  task automatic wait_accept(input string name, output int g);
    g = -1;
    for (int c = 0; c < BOUND; c++) begin
      @(negedge clk);
      if (req_ready_o != '0) begin
        g = int'(grant_id_o);
        return;
      end
    end
    bound_expired(name);
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < BOUND; c++) begin
      @(negedge clk);
      if (busy_o == 1'b0 && tx_ready_i == 1'b1) return;
    end
    bound_expired(name);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic clear_log();
    log_g.delete();
    log_d.delete();
  endtask

  task automatic check_log(input string name, input int exp_g[5], input int exp_d[5]);
    check({name, "_count"}, log_g.size(), 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s_grant%0d", name, k), (log_g.size() > k) ? log_g[k] : -1, exp_g[k]);
      check($sformatf("%s_data%0d",  name, k), (log_d.size() > k) ? log_d[k] : -1, exp_d[k]);
    end
  endtask

  int t2_g[5] = '{0, 1, 2, 3, 0};
  int t2_d[5] = '{'h10, 'h11, 'h12, 'h13, 'h10};
  int t3_g[5] = '{1, 1, 1, 3, 0};
  int t3_d[5] = '{'h31, 'h32, 'h33, 'h43, 'h40};

  // -------------------------------------------------------------------------
  // Directed scenarios.
  // -------------------------------------------------------------------------
  initial begin
    int g;
    int hi;
    int errs;
    int pulses;

    rst_i       = 1'b1;
    req_valid_i = '0;
    req_lock_i  = '0;
    req_data_i  = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    // Reset state.
    check("rst_busy",      busy_o,        1'b0);
    check("rst_send",      tx_send_o,     1'b0);
    check("rst_ready",     req_ready_o,   4'b0000);
    check("rst_grant",     grant_id_o,    3'd0);
    check("rst_data",      tx_data_o,     8'h00);
    check("rst_err",       err_timeout_o, 1'b0);

    // 1: single requester.
    clear_log();
    @(negedge clk);
    req_data_i[23:16] = 8'hAA;
    req_valid_i       = 4'b0100;
    wait_accept("t1_accept", g);
    check("t1_ready_pulse", req_ready_o, 4'b0100);
    check("t1_grant",       g,           2);
    check("t1_data",        tx_data_o,   8'hAA);
    check("t1_send",        tx_send_o,   1'b1);
    req_valid_i = '0;
    wait_idle("t1_idle");
    check("t1_pulses",      log_g.size(), 1);
    check("t1_busy_done",   busy_o,       1'b0);

    // 2: all four valid, plain round robin.
    apply_reset();
    clear_log();
    req_data_i  = 32'h13121110;
    req_valid_i = 4'b1111;
    for (int k = 0; k < 5; k++) wait_accept("t2_accept", g);
    req_valid_i = '0;
    wait_idle("t2_idle");
    check_log("t2", t2_g, t2_d);

    // 3: locked three-byte message from requester 1.
    apply_reset();
    clear_log();
    req_data_i  = {8'h43, 8'h00, 8'h31, 8'h40};
    req_lock_i  = 4'b0010;
    req_valid_i = 4'b0010;
    wait_accept("t3_accept0", g);
    req_valid_i       = 4'b1011;
    req_data_i[15:8]  = 8'h32;
    wait_accept("t3_accept1", g);
    req_data_i[15:8]  = 8'h33;
    wait_accept("t3_accept2", g);
    req_lock_i  = '0;
    req_valid_i = 4'b1001;
    wait_accept("t3_accept3", g);
    req_valid_i = 4'b0001;
    wait_accept("t3_accept4", g);
    req_valid_i = '0;
    wait_idle("t3_idle");
    check_log("t3", t3_g, t3_d);

    // 4: transmitter never starts -> watchdog abort.
    apply_reset();
    manual     = 1'b1;
    tx_ready_i = 1'b1;
    req_data_i = {8'h00, 8'h66, 8'h55, 8'h00};
    req_valid_i = 4'b0010;
    wait_accept("t4_accept", g);
    req_valid_i = '0;
    hi   = 0;
    errs = 0;
    for (int c = 0; c < 40; c++) begin
      if (tx_send_o)     hi++;
      if (err_timeout_o) errs++;
      @(negedge clk);
    end
    check("t4_send_cycles", hi,     16);
    check("t4_err_pulses",  errs,   1);
    check("t4_busy",        busy_o, 1'b0);
    manual      = 1'b0;
    req_valid_i = 4'b0110;
    wait_accept("t4_next", g);
    check("t4_next_grant", g,         2);
    check("t4_next_data",  tx_data_o, 8'h66);
    req_valid_i = '0;
    wait_idle("t4_idle");

    // 5: reset in the middle of a frame.
    apply_reset();
    req_data_i  = {8'hC3, 8'h00, 8'h00, 8'h60};
    req_valid_i = 4'b0001;
    wait_accept("t5_accept", g);
    req_valid_i = '0;
    hi = 0;
    for (int c = 0; c < BOUND && tx_ready_i; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("t5_busy_before", busy_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("t5_busy",  busy_o,        1'b0);
    check("t5_send",  tx_send_o,     1'b0);
    check("t5_ready", req_ready_o,   4'b0000);
    check("t5_grant", grant_id_o,    3'd0);
    check("t5_data",  tx_data_o,     8'h00);
    check("t5_err",   err_timeout_o, 1'b0);
    req_valid_i = 4'b1000;
    wait_accept("t5_after", g);
    check("t5_after_grant", g,         3);
    check("t5_after_data",  tx_data_o, 8'hC3);
    req_valid_i = '0;
    wait_idle("t5_idle");

    // 6: transmitter busy while a request waits.
    manual     = 1'b1;
    tx_ready_i = 1'b0;
    req_data_i  = {8'h00, 8'h00, 8'h77, 8'h00};
    req_valid_i = 4'b0010;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_ready_o != '0) pulses++;
    end
    check("t6_no_grant", pulses, 0);
    check("t6_busy",     busy_o, 1'b0);
    tx_ready_i = 1'b1;
    @(negedge clk);
    check("t6_ready", req_ready_o, 4'b0010);
    check("t6_data",  tx_data_o,   8'h77);
    manual      = 1'b0;
    req_valid_i = '0;
    wait_idle("t6_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
